aud_mem_sched: RTL and testbench

//  Session controller and SRAM arbiter for the audio recorder/player. Latches a

---
 rtl/aud_mem_pkg.sv | 29 ++
 rtl/aud_sram_port.sv | 94 +++++++++
 rtl/aud_mem_sched.sv | 198 +++++++++++++++++++
 tb/tb_aud_mem_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_mem_pkg.sv
// Shared types and constants for the audio session controller and SRAM port.
// AUD_LOOP_PLAY_EN (in aud_mem_sched) selects looping playback.
package aud_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 18;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ACC_CYC_DEF = 2;

  typedef logic [1:0] sess_st_t;
  localparam sess_st_t SESS_IDLE  = 2'd0;
  localparam sess_st_t SESS_REC   = 2'd1;
  localparam sess_st_t SESS_PLAY  = 2'd2;
  localparam sess_st_t SESS_DRAIN = 2'd3;

  typedef logic acc_st_t;
  localparam acc_st_t ACC_FREE = 1'b0;
  localparam acc_st_t ACC_BUSY = 1'b1;

  typedef logic [1:0] gnt_t;
  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_AUD  = 2'd1;
  localparam gnt_t GNT_HOST = 2'd2;

  // Audio may only own the SRAM while a stream is actually running.
  function automatic logic is_stream(sess_st_t st);
    return (st == SESS_REC) || (st == SESS_PLAY);
  endfunction

endpackage

// File: rtl/aud_sram_port.sv
// Access FSM and SRAM pin timing: takes a registered grant, runs ACC_CYC pin
// cycles, captures read data on the last one and pulses ack the cycle after.
module aud_sram_port
  import aud_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic              MCLK,
  input  logic              reset,
  input  gnt_t              gnt,
  input  logic              gnt_we,
  input  logic [ADDR_W-1:0] gnt_addr,
  input  logic [DATA_W-1:0] gnt_wdata,
  output logic              ready,
  output logic              ack,
  output gnt_t              ack_owner,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int unsigned     CNT_W    = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

  acc_st_t           st_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  gnt_t              owner_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic acc_on;
  logic last_cyc;
  logic we_strobe;

  assign acc_on   = (st_q == ACC_BUSY);
  assign last_cyc = (cnt_q == CNT_LAST);
  // WE_N lifts on the final cycle for data hold, unless there is only one cycle.
  assign we_strobe = (ACC_CYC == 1) || !last_cyc;

  // The ack cycle is not grantable so a still-held req is not served twice.
  assign ready = (st_q == ACC_FREE) && !ack_q;

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      st_q    <= ACC_FREE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= GNT_NONE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (st_q == ACC_FREE) begin
        if (ready && (gnt != GNT_NONE)) begin
          st_q    <= ACC_BUSY;
          cnt_q   <= '0;
          we_q    <= gnt_we;
          addr_q  <= gnt_addr;
          wdata_q <= gnt_wdata;
          owner_q <= gnt;
        end
      end else if (last_cyc) begin
        if (!we_q) begin
          rdata_q <= SRAM_DQ_I;
        end
        ack_q <= 1'b1;
        st_q  <= ACC_FREE;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ack        = ack_q;
  assign ack_owner  = owner_q;
  assign rdata      = rdata_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = wdata_q;
  assign SRAM_DQ_OE = acc_on && we_q;
  assign SRAM_WE_N  = !(acc_on && we_q && we_strobe);
  assign SRAM_OE_N  = !(acc_on && !we_q);

endmodule

// File: rtl/aud_mem_sched.sv
// Record/play session controller and SRAM arbiter (audio over host priority).
// Define AUD_LOOP_PLAY_EN to make playback wrap to the window start until stopped.
module aud_mem_sched
  import aud_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              rec_cmd,
  input  logic              play_cmd,
  input  logic              stop_cmd,
  input  logic [ADDR_W-1:0] win_start,
  input  logic [ADDR_W-1:0] win_end,
  output logic              rec_en,
  output logic              play_en,
  input  logic              aud_req,
  input  logic [DATA_W-1:0] aud_wdata,
  output logic              aud_ack,
  output logic [DATA_W-1:0] aud_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  sess_st_t          state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] win_end_q, win_end_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;
`ifdef AUD_LOOP_PLAY_EN
  logic [ADDR_W-1:0] win_start_q, win_start_d;
`endif

  logic [ADDR_W-1:0] addr_inc;
  logic              any_cmd;
  logic              port_ready;
  logic              port_ack;
  gnt_t              port_owner;
  logic [DATA_W-1:0] port_rdata;
  gnt_t              gnt;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  assign addr_inc = cur_addr_q + ADDR_W'(1);
  assign any_cmd  = rec_cmd || play_cmd;
  assign aud_ack  = port_ack && (port_owner == GNT_AUD);
  assign host_ack = port_ack && (port_owner == GNT_HOST);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    win_end_d  = win_end_q;
    done_d     = 1'b0;
    cmd_err_d  = 1'b0;
`ifdef AUD_LOOP_PLAY_EN
    win_start_d = win_start_q;
`endif
    unique case (state_q)
      SESS_IDLE: begin
        if (any_cmd) begin
          if (win_start >= win_end) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d    = rec_cmd ? SESS_REC : SESS_PLAY;
            cur_addr_d = win_start;
            win_end_d  = win_end;
`ifdef AUD_LOOP_PLAY_EN
            win_start_d = win_start;
`endif
          end
        end
      end
      SESS_REC, SESS_PLAY: begin
        cmd_err_d = any_cmd;
        if (aud_ack) begin
          if (addr_inc == win_end_q) begin
`ifdef AUD_LOOP_PLAY_EN
            if (state_q == SESS_PLAY) begin
              cur_addr_d = win_start_q;
            end else begin
              cur_addr_d = addr_inc;
              state_d    = SESS_DRAIN;
            end
`else
            cur_addr_d = addr_inc;
            state_d    = SESS_DRAIN;
`endif
          end else begin
            cur_addr_d = addr_inc;
          end
        end
        if (stop_cmd) begin
          state_d = SESS_DRAIN;
        end
      end
      SESS_DRAIN: begin
        // cur_addr is frozen here; an in-flight audio ack does not advance it.
        cmd_err_d = any_cmd;
        if (port_ready) begin
          done_d  = 1'b1;
          state_d = SESS_IDLE;
        end
      end
      default: state_d = SESS_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      state_q    <= SESS_IDLE;
      cur_addr_q <= '0;
      win_end_q  <= '0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
`ifdef AUD_LOOP_PLAY_EN
      win_start_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      win_end_q  <= win_end_d;
      done_q     <= done_d;
      cmd_err_q  <= cmd_err_d;
`ifdef AUD_LOOP_PLAY_EN
      win_start_q <= win_start_d;
`endif
    end
  end

  // Fixed priority: a running stream must never lose a sample to the host.
  always_comb begin
    gnt       = GNT_NONE;
    gnt_we    = 1'b0;
    gnt_addr  = host_addr;
    gnt_wdata = host_wdata;
    if (port_ready) begin
      if (aud_req && is_stream(state_q)) begin
        gnt       = GNT_AUD;
        gnt_we    = (state_q == SESS_REC);
        gnt_addr  = cur_addr_q;
        gnt_wdata = aud_wdata;
      end else if (host_req) begin
        gnt    = GNT_HOST;
        gnt_we = host_we;
      end
    end
  end

  aud_sram_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ACC_CYC(ACC_CYC)
  ) u_port (
    .MCLK      (MCLK),
    .reset     (reset),
    .gnt       (gnt),
    .gnt_we    (gnt_we),
    .gnt_addr  (gnt_addr),
    .gnt_wdata (gnt_wdata),
    .ready     (port_ready),
    .ack       (port_ack),
    .ack_owner (port_owner),
    .rdata     (port_rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ_O (SRAM_DQ_O),
    .SRAM_DQ_I (SRAM_DQ_I),
    .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  assign aud_rdata  = port_rdata;
  assign host_rdata = port_rdata;
  assign rec_en     = (state_q == SESS_REC);
  assign play_en    = (state_q == SESS_PLAY);
  assign busy       = (state_q != SESS_IDLE);
  assign cur_addr   = cur_addr_q;
  assign done       = done_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_aud_mem_sched.sv
// Directed self-checking bench for aud_mem_sched (default ACC_CYC=2).
module tb_aud_mem_sched;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        rec_cmd, play_cmd, stop_cmd;
  logic [17:0] win_start, win_end;
  logic        rec_en, play_en;
  logic        aud_req;
  logic [15:0] aud_wdata;
  logic        aud_ack;
  logic [15:0] aud_rdata;
  logic        host_req, host_we;
  logic [17:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [17:0] cur_addr;
  logic        busy, done, cmd_err;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
  logic        SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N;
  logic        dq_force;

  always #5 MCLK = ~MCLK;

  // SRAM read data: a fixed pattern of the address, or 0xBEEF when forced.
  assign SRAM_DQ_I = dq_force ? 16'hBEEF : (SRAM_ADDR[15:0] ^ 16'hA500);

  aud_mem_sched dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .rec_cmd   (rec_cmd),
    .play_cmd  (play_cmd),
    .stop_cmd  (stop_cmd),
    .win_start (win_start),
    .win_end   (win_end),
    .rec_en    (rec_en),
    .play_en   (play_en),
    .aud_req   (aud_req),
    .aud_wdata (aud_wdata),
    .aud_ack   (aud_ack),
    .aud_rdata (aud_rdata),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .cur_addr  (cur_addr),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ_O (SRAM_DQ_O),
    .SRAM_DQ_I (SRAM_DQ_I),
    .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pin monitor: logs each write strobe cycle and each read start address.
  logic [17:0] wr_addr_l[$];
  logic [15:0] wr_data_l[$];
  logic [17:0] rd_addr_l[$];
  int          strobes = 0;
  logic        prev_oe_n = 1'b1;

  always @(negedge MCLK) begin
    if (SRAM_WE_N === 1'b0) begin
      wr_addr_l.push_back(SRAM_ADDR);
      wr_data_l.push_back(SRAM_DQ_O);
    end
    if ((SRAM_OE_N === 1'b0) && prev_oe_n) rd_addr_l.push_back(SRAM_ADDR);
    if ((SRAM_WE_N === 1'b0) || (SRAM_OE_N === 1'b0)) strobes++;
    prev_oe_n = (SRAM_OE_N !== 1'b0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acks;
    int   k;
    int   s0;
    logic got;
    logic seen;
    byte  ev[$];

    reset = 1'b0; rec_cmd = 0; play_cmd = 0; stop_cmd = 0;
    win_start = '0; win_end = '0; aud_req = 0; aud_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; dq_force = 0;
    repeat (3) @(negedge MCLK);
    chk("rst_ctrl", {rec_en, play_en, busy, done, cmd_err, aud_ack, host_ack}, 32'h0);
    chk("rst_pins", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 32'h6);
    chk("rst_cur_addr", cur_addr, 32'h0);
    chk("rst_data", {aud_rdata, host_rdata}, 32'h0);
    reset = 1'b1;
    @(negedge MCLK);

    // Record 0x10..0x14 with audio always requesting.
    win_start = 18'h10; win_end = 18'h14; aud_wdata = 16'hCAFE; aud_req = 1; rec_cmd = 1;
    @(negedge MCLK);
    rec_cmd = 0;
    chk("rec_start", {busy, rec_en, play_en}, 32'h6);
    chk("rec_cur_start", cur_addr, 32'h10);
    acks = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge MCLK);
      if (aud_ack) acks++;
      if (done) got = 1;
    end
    aud_req = 0;
    chk("rec_done", got, 32'h1);
    chk("rec_acks", acks, 32'd4);
    chk("rec_busy_end", {busy, rec_en}, 32'h0);
    chk("rec_cur_end", cur_addr, 32'h14);
    chk("rec_nwr", wr_addr_l.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rec_wr_addr", wr_addr_l[i], 32'h10 + i);
      chk("rec_wr_data", wr_data_l[i], 32'hCAFE);
    end
    wr_addr_l.delete(); wr_data_l.delete(); rd_addr_l.delete();

    // Empty window is rejected.
    s0 = strobes;
    win_start = 18'd5; win_end = 18'd5; play_cmd = 1;
    @(negedge MCLK);
    play_cmd = 0;
    chk("empty_cmd_err", cmd_err, 32'h1);
    chk("empty_busy", {busy, play_en}, 32'h0);
    repeat (4) @(negedge MCLK);
    chk("empty_no_strobe", strobes - s0, 32'd0);
    chk("empty_err_pulse", cmd_err, 32'h0);

    // Audio and host request together: audio first, host in the next slot.
    win_start = 18'h20; win_end = 18'h22; aud_wdata = 16'h1111; rec_cmd = 1;
    @(negedge MCLK);
    rec_cmd = 0;
    aud_req = 1; host_req = 1; host_we = 0; host_addr = 18'h55; play_cmd = 1;
    @(negedge MCLK);
    play_cmd = 0;
    chk("busy_cmd_err", cmd_err, 32'h1);
    chk("busy_still_rec", rec_en, 32'h1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge MCLK);
      if (aud_ack) begin
        ev.push_back(8'd1);
        aud_req = 0;
      end
      if (host_ack) begin
        ev.push_back(8'd2);
        chk("arb_host_rdata", host_rdata, 32'hA555);
        host_req = 0;
        aud_req  = 1;
      end
      if (done) got = 1;
    end
    aud_req = 0;
    chk("arb_done", got, 32'h1);
    chk("arb_nev", ev.size(), 32'd3);
    chk("arb_ev0_aud", ev[0], 32'd1);
    chk("arb_ev1_host", ev[1], 32'd2);
    chk("arb_ev2_aud", ev[2], 32'd1);
    chk("arb_nwr", wr_addr_l.size(), 32'd2);
    chk("arb_wr0", wr_addr_l[0], 32'h20);
    chk("arb_wr1", wr_addr_l[1], 32'h21);
    wr_addr_l.delete(); wr_data_l.delete(); rd_addr_l.delete();

    // Stop during the first write of a long window.
    win_start = 18'h30; win_end = 18'h40; aud_wdata = 16'h5A5A; aud_req = 1; rec_cmd = 1;
    @(negedge MCLK);
    rec_cmd = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge MCLK);
      if (SRAM_WE_N === 1'b0) seen = 1;
    end
    chk("stop_wr_seen", seen, 32'h1);
    stop_cmd = 1;
    @(negedge MCLK);
    stop_cmd = 0;
    chk("stop_drain", {busy, rec_en, SRAM_DQ_OE, SRAM_WE_N}, 32'hB);
    acks = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge MCLK);
      if (aud_ack) begin
        acks++;
        aud_req = 0;
      end
      if (done) got = 1;
    end
    aud_req = 0;
    chk("stop_done", got, 32'h1);
    chk("stop_acks", acks, 32'd1);
    chk("stop_cur_frozen", cur_addr, 32'h30);
    chk("stop_nwr", wr_addr_l.size(), 32'd1);
    chk("stop_wr_addr", wr_addr_l[0], 32'h30);
    chk("stop_wr_data", wr_data_l[0], 32'h5A5A);
    wr_addr_l.delete(); wr_data_l.delete(); rd_addr_l.delete();

    // Playback over window 0..3.
    win_start = 18'h0; win_end = 18'h3; aud_req = 1; play_cmd = 1;
    @(negedge MCLK);
    play_cmd = 0;
    chk("play_start", {busy, rec_en, play_en}, 32'h5);
    k = 0; got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge MCLK);
      stop_cmd = 0;
      if (aud_ack) begin
`ifdef AUD_LOOP_PLAY_EN
        chk("play_rdata", aud_rdata, (k % 3) ^ 32'hA500);
        k++;
        if (k == 6) stop_cmd = 1;
`else
        chk("play_rdata", aud_rdata, k ^ 32'hA500);
        k++;
`endif
      end
      if (done) got = 1;
    end
    stop_cmd = 0; aud_req = 0;
    chk("play_done", got, 32'h1);
`ifdef AUD_LOOP_PLAY_EN
    chk("play_acks", k, 32'd6);
    chk("play_nrd", rd_addr_l.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk("play_rd_addr", rd_addr_l[i], i % 3);
    chk("play_cur_end", cur_addr, 32'h0);
`else
    chk("play_acks", k, 32'd3);
    chk("play_nrd", rd_addr_l.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("play_rd_addr", rd_addr_l[i], i);
    chk("play_cur_end", cur_addr, 32'h3);
`endif
    chk("play_busy_end", {busy, play_en}, 32'h0);
    wr_addr_l.delete(); wr_data_l.delete(); rd_addr_l.delete();

    // Host read at the top address.
    dq_force = 1; host_we = 0; host_addr = 18'h3FFFF; host_req = 1;
    got = 0; seen = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge MCLK);
      if ((SRAM_OE_N === 1'b0) && !seen) begin
        seen = 1;
        chk("hrd_addr", SRAM_ADDR, 32'h3FFFF);
      end
      if (host_ack) begin
        got = 1;
        chk("hrd_rdata", host_rdata, 32'hBEEF);
        host_req = 0;
      end
    end
    host_req = 0; dq_force = 0;
    chk("hrd_ack", got, 32'h1);

    // Host write, reset during the strobe.
    host_we = 1; host_addr = 18'h123; host_wdata = 16'h7777; host_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge MCLK);
      if (SRAM_WE_N === 1'b0) seen = 1;
    end
    chk("hwr_seen", seen, 32'h1);
    chk("hwr_pins", {SRAM_ADDR, SRAM_DQ_O}, {14'h0, 18'h123} << 16 | 32'h7777);
    reset = 0;
    @(negedge MCLK);
    chk("rst_mid_pins", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 32'h6);
    chk("rst_mid_ack", host_ack, 32'h0);
    host_req = 0;
    reset = 1;
    seen = 0;
    repeat (4) begin
      @(negedge MCLK);
      if (host_ack) seen = 1;
    end
    chk("rst_mid_no_ack", seen, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
